// File: rtl/if_fetch_queue_if.sv
// Decode-side handshake bundle for if_fetch_queue: {pc, instr} head entry over valid/ready.
interface if_fetch_queue_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_instr;

    modport master (output id_valid, output id_pc, output id_instr, input id_ready);
    modport slave  (input id_valid, input id_pc, input id_instr, output id_ready);
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: issues fetches to 1-cycle imem, buffers {pc, instr} for decode.
// Optional macro IF_FETCH_BYPASS_EN: an arriving response skips an empty FIFO combinationally.
module if_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AW-1:0]           pc,
    output logic                    pc_en,
    input  logic                    flush,
    output logic                    imem_req,
    output logic [AW-1:0]           imem_addr,
    input  logic [DW-1:0]           imem_rdata,
    if_fetch_queue_if.master        id,
    output logic [$clog2(DEPTH):0]  occupancy
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;
    localparam int unsigned CW = OW + 1;

    logic [AW-1:0] mem_pc    [DEPTH];
    logic [DW-1:0] mem_instr [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [OW-1:0] occ;
    logic          inflight;
    logic          kill;
    logic [AW-1:0] inflight_pc;

    logic          issue;
    logic          rsp_ok;
    logic          byp;
    logic          wr_fifo;
    logic          rd_fifo;
    logic [CW-1:0] used;

    // Credits count buffered entries plus the fetch whose response is still coming.
    assign used      = CW'(occ) + CW'(inflight);
    assign issue     = rst & ~flush & (used < CW'(DEPTH));
    assign pc_en     = issue;
    assign imem_req  = issue;
    assign imem_addr = pc;

    // A redirect in the arrival cycle beats the response.
    assign rsp_ok = inflight & ~kill & ~flush;

`ifdef IF_FETCH_BYPASS_EN
    assign byp = rsp_ok & (occ == '0);
`else
    assign byp = 1'b0;
`endif

    assign rd_fifo = (occ != '0) & id.id_ready & ~flush;
    assign wr_fifo = rsp_ok & ~(byp & id.id_ready);

    assign id.id_valid = (occ != '0) | byp;
    assign id.id_pc    = byp ? inflight_pc : mem_pc[head];
    assign id.id_instr = byp ? imem_rdata  : mem_instr[head];
    assign occupancy   = occ;

    // Pointers, count and in-flight tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            occ         <= '0;
            inflight    <= 1'b0;
            kill        <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            kill     <= flush & inflight;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (flush) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                if (rd_fifo) begin
                    head <= head + PW'(1);
                end
                if (wr_fifo) begin
                    tail <= tail + PW'(1);
                end
                occ <= occ + OW'(wr_fifo) - OW'(rd_fifo);
            end
        end
    end

    // Entry storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (wr_fifo) begin
            mem_pc[tail]    <= inflight_pc;
            mem_instr[tail] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_if_fetch_queue;
    localparam int unsigned DEPTH = 4;
`ifdef IF_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 1;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [2:0]  occupancy;
    logic [31:0] rsp_addr;

    if_fetch_queue_if #(.AW(32), .DW(32)) ifc ();

    if_fetch_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .pc         (pc),
        .pc_en      (pc_en),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .id         (ifc.master),
        .occupancy  (occupancy)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: data for the address presented one cycle earlier.
    always @(posedge clk) rsp_addr <= imem_addr;
    assign imem_rdata = instr_of(rsp_addr);

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    ent_t        q[$];
    bit          m_pend;
    bit          m_kill;
    logic [31:0] m_pend_pc;

    logic        obs_pc_en;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [2:0]  obs_occ;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc_en"}, 64'(pc_en), 64'(0));
        chk({tag, "_req"},   64'(imem_req), 64'(0));
        chk({tag, "_valid"}, 64'(ifc.id_valid), 64'(0));
        chk({tag, "_occ"},   64'(occupancy), 64'(0));
        chk({tag, "_pc"},    64'(ifc.id_pc), 64'(0));
        chk({tag, "_instr"}, 64'(ifc.id_instr), 64'(0));
    endtask

    task automatic model_reset();
        q.delete();
        m_pend    = 1'b0;
        m_kill    = 1'b0;
        m_pend_pc = '0;
    endtask

    // One clock: drive inputs after negedge, compare against the model, then advance model and PC register.
    task automatic step(input bit fl, input logic [31:0] tgt, input bit rdy);
        bit   e_issue;
        bit   rsp;
        bit   byp;
        bit   e_valid;
        ent_t e;
        flush        = fl;
        ifc.id_ready = rdy;
        #1;
        e_issue = ((q.size() + int'(m_pend)) < int'(DEPTH)) && !fl;
        rsp     = m_pend && !m_kill && !fl;
        byp     = BYP && rsp && (q.size() == 0);
        e_valid = (q.size() != 0) || byp;
        if (q.size() != 0) e = q[0];
        else               e = '{pc: m_pend_pc, instr: instr_of(m_pend_pc)};
        chk("pc_en",     64'(pc_en),        64'(e_issue));
        chk("imem_req",  64'(imem_req),     64'(e_issue));
        chk("imem_addr", 64'(imem_addr),    64'(pc));
        chk("id_valid",  64'(ifc.id_valid), 64'(e_valid));
        chk("occupancy", 64'(occupancy),    64'(q.size()));
        if (e_valid) begin
            chk("id_pc",    64'(ifc.id_pc),    64'(e.pc));
            chk("id_instr", 64'(ifc.id_instr), 64'(e.instr));
        end
        obs_pc_en = pc_en;
        obs_valid = ifc.id_valid;
        obs_pc    = ifc.id_pc;
        obs_occ   = occupancy;
        @(posedge clk);
        @(negedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (rsp && !(byp && rdy)) q.push_back('{pc: m_pend_pc, instr: instr_of(m_pend_pc)});
        end
        m_kill = fl && m_pend;
        m_pend = e_issue;
        if (e_issue) m_pend_pc = pc;
        pc = fl ? tgt : (e_issue ? pc + 32'd4 : pc);
    endtask

    initial begin
        logic        v_arr [5];
        logic [31:0] p_arr [5];
        int          first;
        int          issues;
        bit          seen;

        clk          = 1'b0;
        rst_n        = 1'b1;
        pc           = 32'h0;
        flush        = 1'b0;
        ifc.id_ready = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("rst0");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Stream from pc=0 with decode always ready.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1);
            v_arr[i] = obs_valid;
            p_arr[i] = obs_pc;
            chk("stream_pc_en", 64'(obs_pc_en), 64'(1));
            if (BYP && i > 0) chk("bypass_occ", 64'(obs_occ), 64'(0));
        end
        first = -1;
        for (int i = 4; i >= 0; i--) if (v_arr[i]) first = i;
        chk("first_valid_cycle", 64'(first), 64'(LAT));
        chk("seq_pc0", 64'(p_arr[LAT]),     64'(32'h0));
        chk("seq_pc1", 64'(p_arr[LAT + 1]), 64'(32'h4));
        chk("seq_pc2", 64'(p_arr[LAT + 2]), 64'(32'h8));

        // Redirect the cycle after 0x10 issued.
        chk("pre_flush_pc", 64'(pc), 64'(32'h14));
        step(1'b1, 32'h40, 1'b1);

        // Decode stalled: exactly DEPTH fetches may be outstanding.
        issues = 0;
        seen   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b0);
            if (i == 0) begin
                chk("post_flush_occ",   64'(obs_occ),   64'(0));
                chk("post_flush_valid", 64'(obs_valid), 64'(0));
            end
            if (obs_pc_en) issues++;
            if (obs_valid && !seen) begin
                chk("flush_target_pc", 64'(obs_pc), 64'(32'h40));
                seen = 1'b1;
            end
        end
        chk("flush_target_seen", 64'(seen), 64'(1));
        chk("full_issue_count", 64'(issues), 64'(DEPTH));
        step(1'b0, '0, 1'b1);
        chk("full_pc_en", 64'(obs_pc_en), 64'(0));
        chk("full_occ",   64'(obs_occ),   64'(DEPTH));
        issues = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0);
            if (i == 0) chk("credit_issue", 64'(obs_pc_en), 64'(1));
            if (obs_pc_en) issues++;
        end
        chk("credit_issue_count", 64'(issues), 64'(1));

        // Steady enqueue+dequeue at occupancy 2 across pointer wrap.
        for (int i = 0; i < 14; i++) begin
            step(1'b0, '0, 1'b1);
            if (i >= 3) chk("steady_occ", 64'(obs_occ), 64'(2));
        end

        // Random traffic with occasional redirects.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0);
        end

        // Build occupancy 3 then pull reset mid-stream.
        step(1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        #1 chk("pre_reset_occ", 64'(occupancy), 64'(3));
        rst_n = 1'b0;
        model_reset();
        pc = 32'h300;
        #1 chk_reset_outputs("rst_mid");
        @(negedge clk);
        chk_reset_outputs("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b1);
            if (obs_valid && !seen) begin
                chk("post_reset_first_pc", 64'(obs_pc), 64'(32'h300));
                seen = 1'b1;
            end
        end
        chk("post_reset_seen", 64'(seen), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
